// File: rtl/sigma_delta_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sigma_delta_adc_sequencer
// Description : Per-channel power/warm-up sequencing for a bank of
//               sigma-delta ADCs, with round-robin merging of the channel
//               samples into one tagged valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_adc_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int ADC_BITLEN     = 16,
    parameter int WARMUP_SAMPLES = 3,
    localparam int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CHANNELS-1:0]              ch_enable,
    output logic [NUM_CHANNELS-1:0]              adc_rst,
    input  logic [NUM_CHANNELS*ADC_BITLEN-1:0]   adc_data,
    input  logic [NUM_CHANNELS-1:0]              adc_vld,
    output logic [ADC_BITLEN-1:0]                m_data,
    output logic [CH_W-1:0]                      m_chan,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [NUM_CHANNELS-1:0]              ch_running,
    output logic [NUM_CHANNELS-1:0]              overrun,
    input  logic                                 ovr_clear
);

    localparam logic [1:0] c_ST_OFF    = 2'd0;
    localparam logic [1:0] c_ST_WARMUP = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;

    localparam bit         c_NO_WARMUP = (WARMUP_SAMPLES == 0);
    localparam logic [7:0] c_WARM_LAST = c_NO_WARMUP ? 8'd0 : 8'(WARMUP_SAMPLES - 1);

    logic [NUM_CHANNELS-1:0] w_load;
    logic [NUM_CHANNELS-1:0] w_rst_dec;
    logic [NUM_CHANNELS-1:0] w_run_dec;

    logic [NUM_CHANNELS-1:0] r_adc_rst;
    logic [NUM_CHANNELS-1:0] r_ch_running;
    logic [NUM_CHANNELS-1:0] r_hold_full;
    logic [NUM_CHANNELS-1:0] r_overrun;
    logic [ADC_BITLEN-1:0]   r_hold_data [NUM_CHANNELS];

    logic                    r_m_valid;
    logic [ADC_BITLEN-1:0]   r_m_data;
    logic [CH_W-1:0]         r_m_chan;
    logic [CH_W-1:0]         r_ptr;

    logic                    w_slot_free;
    logic                    w_any_sel;
    logic                    w_grant;
    logic [CH_W-1:0]         w_sel;
    logic [CH_W-1:0]         w_cand;
    logic [NUM_CHANNELS-1:0] w_gnt_oh;

    // ------------------------------------------------------------------
    // Per-channel sequencer
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            logic [1:0] r_state;
            logic [1:0] w_state_nxt;
            logic [7:0] r_warm_cnt;
            logic [7:0] w_warm_cnt_nxt;
            logic       w_rst_o;
            logic       w_run_o;
            logic       w_load_o;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= c_ST_OFF;
                    r_warm_cnt <= 8'd0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_warm_cnt <= w_warm_cnt_nxt;
                end
            end

            always_comb begin
                w_state_nxt    = r_state;
                w_warm_cnt_nxt = r_warm_cnt;
                if (!ch_enable[i]) begin
                    w_state_nxt    = c_ST_OFF;
                    w_warm_cnt_nxt = 8'd0;
                end else begin
                    case (r_state)
                        c_ST_OFF: begin
                            w_warm_cnt_nxt = 8'd0;
                            w_state_nxt    = c_NO_WARMUP ? c_ST_RUN : c_ST_WARMUP;
                        end
                        c_ST_WARMUP: begin
                            // Strobes while settling are counted and dropped
                            if (adc_vld[i]) begin
                                if (r_warm_cnt == c_WARM_LAST) begin
                                    w_state_nxt = c_ST_RUN;
                                end else begin
                                    w_warm_cnt_nxt = r_warm_cnt + 8'd1;
                                end
                            end
                        end
                        c_ST_RUN: begin
                            w_state_nxt = c_ST_RUN;
                        end
                        default: begin
                            w_state_nxt    = c_ST_OFF;
                            w_warm_cnt_nxt = 8'd0;
                        end
                    endcase
                end
            end

            always_comb begin
                w_rst_o  = 1'b1;
                w_run_o  = 1'b0;
                w_load_o = 1'b0;
                case (r_state)
                    c_ST_WARMUP: begin
                        w_rst_o = 1'b0;
                    end
                    c_ST_RUN: begin
                        w_rst_o  = 1'b0;
                        w_run_o  = 1'b1;
                        w_load_o = ch_enable[i] & adc_vld[i];
                    end
                    default: begin
                        w_rst_o = 1'b1;
                    end
                endcase
            end

            assign w_rst_dec[i] = w_rst_o;
            assign w_run_dec[i] = w_run_o;
            assign w_load[i]    = w_load_o;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_rst    <= '1;
            r_ch_running <= '0;
        end else begin
            r_adc_rst    <= w_rst_dec;
            r_ch_running <= w_run_dec;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: search starts one past the last granted channel
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_free = !r_m_valid || m_ready;
        w_any_sel   = 1'b0;
        w_sel       = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            w_cand = CH_W'((int'(r_ptr) + k) % NUM_CHANNELS);
            if (!w_any_sel && r_hold_full[w_cand]) begin
                w_any_sel = 1'b1;
                w_sel     = w_cand;
            end
        end
        w_grant  = w_slot_free && w_any_sel;
        w_gnt_oh = '0;
        if (w_grant) begin
            w_gnt_oh[w_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Holding registers and sticky overrun flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full <= '0;
            r_overrun   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                // A grant in the same cycle frees the slot, so no overrun then
                if (w_load[i] && r_hold_full[i] && !w_gnt_oh[i]) begin
                    r_overrun[i] <= 1'b1;
                end else if (ovr_clear) begin
                    r_overrun[i] <= 1'b0;
                end

                if (w_load[i]) begin
                    r_hold_full[i] <= 1'b1;
                    r_hold_data[i] <= adc_data[i*ADC_BITLEN +: ADC_BITLEN];
                end else if (!ch_enable[i] || w_gnt_oh[i]) begin
                    r_hold_full[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_chan  <= '0;
            r_ptr     <= '0;
        end else if (w_grant) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_hold_data[w_sel];
            r_m_chan  <= w_sel;
            r_ptr     <= w_sel;
        end else if (w_slot_free) begin
            r_m_valid <= 1'b0;
        end
    end

    assign adc_rst    = r_adc_rst;
    assign ch_running = r_ch_running;
    assign overrun    = r_overrun;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_chan     = r_m_chan;

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigma_delta_adc_sequencer
// Description : Directed and randomized bench for sigma_delta_adc_sequencer
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_adc_sequencer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int WS = 3;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     ch_enable;
    logic [N-1:0]     adc_rst;
    logic [N*W-1:0]   adc_data;
    logic [N-1:0]     adc_vld;
    logic [W-1:0]     m_data;
    logic [CW-1:0]    m_chan;
    logic             m_valid;
    logic             m_ready;
    logic [N-1:0]     ch_running;
    logic [N-1:0]     overrun;
    logic             ovr_clear;

    always #5 clk = ~clk;

    sigma_delta_adc_sequencer #(
        .NUM_CHANNELS   (N),
        .ADC_BITLEN     (W),
        .WARMUP_SAMPLES (WS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_enable  (ch_enable),
        .adc_rst    (adc_rst),
        .adc_data   (adc_data),
        .adc_vld    (adc_vld),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .ch_running (ch_running),
        .overrun    (overrun),
        .ovr_clear  (ovr_clear)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Behavioural model: channel is "active" one cycle after enable is seen,
    // "running" once WS strobes have been counted while active.
    bit [N-1:0]  md_active, md_hfull, md_ovr;
    int          md_warm [N];
    logic [W-1:0] md_hval [N];
    bit [N-1:0]  e_rst, e_run;
    bit          e_valid;
    logic [W-1:0] e_data;
    int          e_chan;
    int          md_ptr;

    logic [W-1:0] got_q [$];
    int           got_ch_q [$];

    function automatic void model_reset();
        md_active = '0; md_hfull = '0; md_ovr = '0;
        e_rst = '1; e_run = '0; e_valid = 1'b0; e_data = '0; e_chan = 0; md_ptr = 0;
        for (int i = 0; i < N; i++) begin
            md_warm[i] = 0;
            md_hval[i] = '0;
        end
    endfunction

    function automatic void model_step(input logic [N-1:0] en, input logic [N-1:0] vld,
                                       input logic [N*W-1:0] data, input bit rdy, input bit clr);
        bit [N-1:0] run_now;
        bit         free;
        bit         ld;
        int         g;
        for (int i = 0; i < N; i++) run_now[i] = md_active[i] && (md_warm[i] >= WS);
        e_rst = ~md_active;
        e_run = run_now;
        free  = !e_valid || rdy;
        g     = -1;
        if (free) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && md_hfull[(md_ptr + k) % N]) g = (md_ptr + k) % N;
            end
        end
        if (g >= 0) begin
            e_valid = 1'b1; e_data = md_hval[g]; e_chan = g; md_ptr = g;
        end else if (free) begin
            e_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            ld = en[i] && run_now[i] && vld[i];
            if (ld && md_hfull[i] && g != i) md_ovr[i] = 1'b1;
            else if (clr) md_ovr[i] = 1'b0;
            if (ld) begin
                md_hfull[i] = 1'b1;
                md_hval[i]  = data[i*W +: W];
            end else if (!en[i] || g == i) begin
                md_hfull[i] = 1'b0;
            end
            if (!en[i]) begin
                md_active[i] = 1'b0; md_warm[i] = 0;
            end else if (!md_active[i]) begin
                md_active[i] = 1'b1; md_warm[i] = 0;
            end else if (!run_now[i] && vld[i]) begin
                md_warm[i]++;
            end
        end
    endfunction

    task automatic compare_all();
        check("m_valid", {31'd0, m_valid}, {31'd0, e_valid});
        if (e_valid) begin
            check("m_data", {16'd0, m_data}, {16'd0, e_data});
            check("m_chan", {30'd0, m_chan}, e_chan);
        end
        check("adc_rst", {28'd0, adc_rst}, {28'd0, e_rst});
        check("ch_running", {28'd0, ch_running}, {28'd0, e_run});
        check("overrun", {28'd0, overrun}, {28'd0, md_ovr});
    endtask

    // One clock: compare at the falling edge, drive, advance the model
    task automatic cycle(input logic [N-1:0] en, input logic [N-1:0] vld,
                         input logic [N*W-1:0] data, input bit rdy, input bit clr);
        compare_all();
        if (m_valid === 1'b1 && rdy) begin
            got_q.push_back(m_data);
            got_ch_q.push_back(int'(m_chan));
        end
        ch_enable = en; adc_vld = vld; adc_data = data; m_ready = rdy; ovr_clear = clr;
        model_step(en, vld, data, rdy, clr);
        @(negedge clk);
    endtask

    function automatic logic [N*W-1:0] one(input int ch, input logic [W-1:0] v);
        logic [N*W-1:0] d;
        d = '0;
        d[ch*W +: W] = v;
        return d;
    endfunction

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic idle(input logic [N-1:0] en, input int n, input bit rdy);
        for (int k = 0; k < n; k++) cycle(en, '0, '0, rdy, 1'b0);
    endtask

    task automatic random_phase(input int ncyc, input logic [N-1:0] en0);
        logic [N-1:0] en;
        logic [N-1:0] vld;
        en = en0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 63) == 0) en[i] = ~en[i];
                vld[i] = ($urandom_range(0, 9) < 3);
            end
            cycle(en, vld, rnd_data(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] burst;
        rst_n = 1'b0; ch_enable = '0; adc_vld = '0; adc_data = '0; m_ready = 1'b0; ovr_clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // ch0 alone: first three strobes are warm-up, 4 and 5 come out
        got_q.delete(); got_ch_q.delete();
        cycle(4'b0001, '0, '0, 1'b1, 1'b0);
        for (int s = 1; s <= 5; s++) begin
            cycle(4'b0001, 4'b0001, one(0, W'(s)), 1'b1, 1'b0);
            idle(4'b0001, 2, 1'b1);
        end
        idle(4'b0001, 3, 1'b1);
        check("warm_count", got_q.size(), 2);
        check("warm_first", (got_q.size() > 0) ? {16'd0, got_q[0]} : 32'hDEAD, 32'h4);
        check("warm_second", (got_q.size() > 1) ? {16'd0, got_q[1]} : 32'hDEAD, 32'h5);

        // All channels up, then a ch3 sample so the next search starts at 0
        cycle(4'b1111, '0, '0, 1'b1, 1'b0);
        for (int r = 0; r < WS; r++) begin
            cycle(4'b1111, 4'b1111, rnd_data(), 1'b1, 1'b0);
            idle(4'b1111, 2, 1'b1);
        end
        idle(4'b1111, 4, 1'b1);
        cycle(4'b1111, 4'b1000, one(3, 16'h0033), 1'b1, 1'b0);
        idle(4'b1111, 4, 1'b1);
        got_q.delete(); got_ch_q.delete();
        burst = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        cycle(4'b1111, 4'b1111, burst, 1'b1, 1'b0);
        idle(4'b1111, 6, 1'b1);
        cycle(4'b1111, 4'b1111, burst, 1'b1, 1'b0);
        idle(4'b1111, 6, 1'b1);
        check("burst_count", got_q.size(), 8);
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
            check("burst_chan", got_ch_q[k], k % 4);
            check("burst_data", {16'd0, got_q[k]}, 32'hA0 + (k % 4));
        end

        // Stalled output: ch1 overwrites its held sample
        got_q.delete(); got_ch_q.delete();
        cycle(4'b1111, 4'b0001, one(0, 16'h0BAD), 1'b0, 1'b0);
        idle(4'b1111, 2, 1'b0);
        cycle(4'b1111, 4'b0010, one(1, 16'h1111), 1'b0, 1'b0);
        idle(4'b1111, 2, 1'b0);
        cycle(4'b1111, 4'b0010, one(1, 16'h2222), 1'b0, 1'b0);
        idle(4'b1111, 4, 1'b0);
        check("ovr_set", {31'd0, overrun[1]}, 32'd1);
        idle(4'b1111, 4, 1'b1);
        check("stall_count", got_q.size(), 2);
        check("stall_second", (got_q.size() > 1) ? {16'd0, got_q[1]} : 32'hDEAD, 32'h2222);
        cycle(4'b1111, '0, '0, 1'b1, 1'b1);
        idle(4'b1111, 2, 1'b1);

        // ch2 grant and new strobe in the same cycle
        got_q.delete(); got_ch_q.delete();
        cycle(4'b1111, 4'b0100, one(2, 16'hC001), 1'b0, 1'b0);
        idle(4'b1111, 1, 1'b0);
        cycle(4'b1111, 4'b0100, one(2, 16'hC002), 1'b0, 1'b0);
        idle(4'b1111, 1, 1'b0);
        cycle(4'b1111, 4'b0100, one(2, 16'hC003), 1'b1, 1'b0);
        idle(4'b1111, 4, 1'b1);
        check("overlap_count", got_q.size(), 3);
        check("overlap_last", (got_q.size() > 2) ? {16'd0, got_q[2]} : 32'hDEAD, 32'hC003);

        // Disable ch3 while its sample sits in the output register
        got_q.delete(); got_ch_q.delete();
        cycle(4'b1111, 4'b1000, one(3, 16'hD003), 1'b0, 1'b0);
        idle(4'b1111, 2, 1'b0);
        cycle(4'b0111, 4'b1000, one(3, 16'hD004), 1'b0, 1'b0);
        cycle(4'b0111, 4'b1000, one(3, 16'hD005), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(4'b0111, 4'b1000, one(3, 16'hD006), 1'b1, 1'b0);
        check("dis_count", got_q.size(), 1);
        check("dis_chan", (got_ch_q.size() > 0) ? got_ch_q[0] : 99, 3);

        random_phase(1500, 4'b1111);

        // Asynchronous reset while the output holds a sample
        begin
            int k;
            k = 0;
            while (k < 50 && m_valid !== 1'b1) begin
                cycle(4'b1111, 4'b1111, rnd_data(), 1'b0, 1'b0);
                k++;
            end
            check("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, m_valid}, 32'd0);
        check("arst_adc_rst", {28'd0, adc_rst}, 32'hF);
        check("arst_overrun", {28'd0, overrun}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        got_q.delete(); got_ch_q.delete();
        cycle(4'b1111, 4'b1111, rnd_data(), 1'b1, 1'b0);
        for (int r = 0; r < WS; r++) cycle(4'b1111, 4'b1111, rnd_data(), 1'b1, 1'b0);
        idle(4'b1111, 3, 1'b1);
        check("post_rst_quiet", got_q.size(), 0);
        random_phase(400, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
